// File: rtl/fir_coeff_loader.sv
// Coefficient SRAM loader: streams ADDR_DEPTH taps into SRAM, sweeps reads over them, then enables the FIR.
// Optional running checksum of the accepted coefficients is built when FIR_COEFF_CHECKSUM_EN is defined.
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_DEPTH = 33
) (
    input  logic                         iClk_12M,
    input  logic                         iRsn,
    input  logic                         iLoadStart,
    input  logic                         iAbort,
    input  logic                         iCoeffValid,
    input  logic [DATA_WIDTH-1:0]        iCoeff,
    output logic                         oCoeffReady,
    output logic                         oCsnRam,
    output logic                         oWrnRam,
    output logic [5:0]                   oAddrRam,
    output logic [DATA_WIDTH-1:0]        oWrDtRam,
    output logic                         oBusy,
    output logic                         oDone,
    output logic                         oFirEn,
    output logic signed [DATA_WIDTH+5:0] oChecksum
);

    localparam logic [5:0] LAST_TAP = 6'(ADDR_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] cnt;
    logic       transfer;

    assign oCoeffReady = (state == WRITE);
    assign transfer    = iCoeffValid && oCoeffReady;

    // Abort takes priority over a coincident transfer, so a dropped tap never reaches the SRAM.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state    <= IDLE;
            cnt      <= '0;
            oCsnRam  <= 1'b1;
            oWrnRam  <= 1'b1;
            oAddrRam <= '0;
            oWrDtRam <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oFirEn   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    oCsnRam <= 1'b1;
                    oWrnRam <= 1'b1;
                    if (iLoadStart) begin
                        state  <= WRITE;
                        cnt    <= 6'd1;
                        oFirEn <= 1'b0;
                        oBusy  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (iAbort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        oCsnRam <= 1'b1;
                        oWrnRam <= 1'b1;
                        oFirEn  <= 1'b0;
                        oBusy   <= 1'b0;
                    end else if (transfer) begin
                        oCsnRam  <= 1'b0;
                        oWrnRam  <= 1'b0;
                        oAddrRam <= cnt;
                        oWrDtRam <= iCoeff;
                        if (cnt == LAST_TAP) begin
                            state <= READ;
                            cnt   <= 6'd1;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end else begin
                        oCsnRam <= 1'b1;
                        oWrnRam <= 1'b1;
                    end
                end
                READ: begin
                    if (iAbort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        oCsnRam <= 1'b1;
                        oWrnRam <= 1'b1;
                        oFirEn  <= 1'b0;
                        oBusy   <= 1'b0;
                    end else begin
                        oCsnRam  <= 1'b0;
                        oWrnRam  <= 1'b1;
                        oAddrRam <= cnt;
                        if (cnt == LAST_TAP) begin
                            state <= DONE;
                            cnt   <= '0;
                            oBusy <= 1'b0;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    oCsnRam <= 1'b1;
                    oWrnRam <= 1'b1;
                    oDone   <= 1'b1;
                    oFirEn  <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    oCsnRam <= 1'b1;
                    oWrnRam <= 1'b1;
                end
            endcase
        end
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    logic signed [DATA_WIDTH+5:0] checksum;

    // Six guard bits cover the sum of up to 63 full-scale taps without overflow.
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            checksum <= '0;
        end else if (state == IDLE && iLoadStart) begin
            checksum <= '0;
        end else if (transfer && !iAbort) begin
            checksum <= checksum + {{6{iCoeff[DATA_WIDTH-1]}}, iCoeff};
        end
    end

    assign oChecksum = checksum;
`else
    assign oChecksum = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: stimulus queues expected SRAM strobes and done events, a negedge monitor checks them.
module tb_fir_coeff_loader;

    localparam int DW    = 16;
    localparam int DEPTH = 33;

    logic               iClk_12M = 1'b0;
    logic               iRsn;
    logic               iLoadStart;
    logic               iAbort;
    logic               iCoeffValid;
    logic [DW-1:0]      iCoeff;
    logic               oCoeffReady;
    logic               oCsnRam;
    logic               oWrnRam;
    logic [5:0]         oAddrRam;
    logic [DW-1:0]      oWrDtRam;
    logic               oBusy;
    logic               oDone;
    logic               oFirEn;
    logic signed [DW+5:0] oChecksum;

    typedef struct {
        bit     is_done;
        bit     wr;
        int     addr;
        longint data;
        longint cyc;
    } ev_t;

    ev_t           sb[$];
    logic [DW-1:0] mem [0:63];
    longint        cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;
    bit            prev_done = 1'b0;

    fir_coeff_loader #(
        .DATA_WIDTH(DW),
        .ADDR_DEPTH(DEPTH)
    ) dut (
        .iClk_12M   (iClk_12M),
        .iRsn       (iRsn),
        .iLoadStart (iLoadStart),
        .iAbort     (iAbort),
        .iCoeffValid(iCoeffValid),
        .iCoeff     (iCoeff),
        .oCoeffReady(oCoeffReady),
        .oCsnRam    (oCsnRam),
        .oWrnRam    (oWrnRam),
        .oAddrRam   (oAddrRam),
        .oWrDtRam   (oWrDtRam),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oFirEn     (oFirEn),
        .oChecksum  (oChecksum)
    );

    always #5 iClk_12M = ~iClk_12M;

    always @(posedge iClk_12M) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DW-1:0] coefFor(input int mode, input int k);
        logic [DW-1:0] c;
        case (mode)
            1:       c = 16'h7FFF;
            2:       c = 16'h8000;
            default: c = 16'(3 * k - 50);
        endcase
        return c;
    endfunction

    // Monitor: every SRAM strobe or done pulse must match the head of the scoreboard.
    always @(negedge iClk_12M) begin
        if (!iRsn) begin
            prev_done = 1'b0;
        end else begin
            ev_t ev;
            if (prev_done) checkOutput("done_pulse_width", longint'(oDone), 0);
            prev_done = oDone;
            if (!oCsnRam) begin
                if (!oWrnRam) mem[oAddrRam] = oWrDtRam;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_strobe_addr", longint'(oAddrRam), -1);
                end else begin
                    ev = sb.pop_front();
                    checkOutput("strobe_kind", longint'(ev.is_done), 0);
                    checkOutput("strobe_wrn", longint'(oWrnRam), longint'(!ev.wr));
                    checkOutput("strobe_addr", longint'(oAddrRam), longint'(ev.addr));
                    if (ev.wr) checkOutput("write_data", longint'(oWrDtRam), ev.data);
                    checkOutput("strobe_cycle", cyc, ev.cyc);
                end
            end
            if (oDone) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    ev = sb.pop_front();
                    checkOutput("done_kind", longint'(ev.is_done), 1);
                    checkOutput("done_cycle", cyc, ev.cyc);
                    checkOutput("done_checksum", longint'(oChecksum), ev.data);
                    checkOutput("done_firen", longint'(oFirEn), 1);
                    checkOutput("done_csn", longint'(oCsnRam), 1);
                    checkOutput("done_busy", longint'(oBusy), 0);
                end
            end
        end
    end

    // Drives one update; inputs change 1 time unit after an edge.
    task automatic applyStimulus(input int mode, input int stall_after, input int abort_tap);
        longint        s;
        longint        sum;
        longint        e;
        logic [DW-1:0] c;
        ev_t           ev;
        sum        = 0;
        iLoadStart = 1'b1;
        s          = cyc + 1;
        @(posedge iClk_12M); #1;
        iLoadStart = 1'b0;
        checkOutput("start_busy", longint'(oBusy), 1);
        for (int k = 1; k <= DEPTH; k++) begin
            c           = coefFor(mode, k);
            iCoeffValid = 1'b1;
            iCoeff      = c;
            if (k == abort_tap) begin
                iAbort = 1'b1;
                @(posedge iClk_12M); #1;
                iAbort = 1'b0;
                checkOutput("abort_busy", longint'(oBusy), 0);
                checkOutput("abort_ready", longint'(oCoeffReady), 0);
                checkOutput("abort_firen", longint'(oFirEn), 0);
                checkOutput("abort_csn", longint'(oCsnRam), 1);
                repeat (3) @(posedge iClk_12M);
                #1;
                iCoeffValid = 1'b0;
                checkOutput("abort_still_idle", longint'(oBusy), 0);
                return;
            end
            ev = '{is_done: 1'b0, wr: 1'b1, addr: k, data: longint'(c), cyc: cyc + 1};
            sb.push_back(ev);
            sum += longint'($signed(c));
            @(posedge iClk_12M); #1;
            if (k == stall_after) begin
                iCoeffValid = 1'b0;
                iCoeff      = 16'hDEAD;
                repeat (5) @(posedge iClk_12M);
                #1;
            end
        end
        iCoeffValid = 1'b0;
        e = s + DEPTH + ((stall_after > 0) ? 5 : 0);
        for (int k = 1; k <= DEPTH; k++) begin
            ev = '{is_done: 1'b0, wr: 1'b0, addr: k, data: 0, cyc: e + k};
            sb.push_back(ev);
        end
`ifdef FIR_COEFF_CHECKSUM_EN
        ev = '{is_done: 1'b1, wr: 1'b0, addr: 0, data: sum, cyc: s + 67 + ((stall_after > 0) ? 5 : 0)};
`else
        ev = '{is_done: 1'b1, wr: 1'b0, addr: 0, data: 0, cyc: s + 67 + ((stall_after > 0) ? 5 : 0)};
`endif
        sb.push_back(ev);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(posedge iClk_12M); #1;
        end
        checkOutput(name, longint'(sb.size()), 0);
        repeat (3) @(posedge iClk_12M);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_csn"}, longint'(oCsnRam), 1);
        checkOutput({tag, "_wrn"}, longint'(oWrnRam), 1);
        checkOutput({tag, "_addr"}, longint'(oAddrRam), 0);
        checkOutput({tag, "_wrdt"}, longint'(oWrDtRam), 0);
        checkOutput({tag, "_ready"}, longint'(oCoeffReady), 0);
        checkOutput({tag, "_busy"}, longint'(oBusy), 0);
        checkOutput({tag, "_done"}, longint'(oDone), 0);
        checkOutput({tag, "_firen"}, longint'(oFirEn), 0);
        checkOutput({tag, "_checksum"}, longint'(oChecksum), 0);
    endtask

    task automatic checkSram(input string name);
        int bad;
        bad = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (mem[k] !== coefFor(0, k)) bad++;
        end
        checkOutput(name, longint'(bad), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iRsn        = 1'b0;
        iLoadStart  = 1'b0;
        iAbort      = 1'b0;
        iCoeffValid = 1'b0;
        iCoeff      = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (3) @(posedge iClk_12M);
        #1;
        checkResetValues("reset");
        iRsn = 1'b1;
        repeat (2) @(posedge iClk_12M);
        #1;

        $display("[TB] full load");
        applyStimulus(0, 0, 0);
        waitDrain("full_drain");
        checkSram("full_sram");
        checkOutput("full_firen_hold", longint'(oFirEn), 1);

        $display("[TB] stalled stream");
        applyStimulus(0, 10, 0);
        waitDrain("stall_drain");
        checkSram("stall_sram");

        $display("[TB] abort at tap 20");
        applyStimulus(0, 0, 20);
        waitDrain("abort_drain");
        checkOutput("abort_firen_low", longint'(oFirEn), 0);
        applyStimulus(0, 0, 0);
        waitDrain("reload_drain");
        checkOutput("reload_firen", longint'(oFirEn), 1);

        $display("[TB] start while busy then async reset");
        applyStimulus(0, 0, 0);
        repeat (5) @(posedge iClk_12M);
        #1;
        iLoadStart = 1'b1;
        @(posedge iClk_12M); #1;
        iLoadStart = 1'b0;
        checkOutput("busy_start_ignored_busy", longint'(oBusy), 1);
        checkOutput("busy_start_ignored_addr", longint'(oAddrRam), 6);
        checkOutput("busy_start_ignored_wrn", longint'(oWrnRam), 1);
        repeat (3) @(posedge iClk_12M);
        #1;
        iRsn = 1'b0;
        #1;
        checkResetValues("async_reset");
        sb.delete();
        @(posedge iClk_12M); #1;
        checkOutput("async_reset_no_strobe", longint'(oCsnRam), 1);
        iRsn = 1'b1;
        repeat (2) @(posedge iClk_12M);
        #1;
        checkResetValues("after_reset");

        $display("[TB] checksum positive full scale");
        applyStimulus(1, 0, 0);
        waitDrain("chk_pos_drain");
        $display("[TB] checksum negative full scale");
        applyStimulus(2, 0, 0);
        waitDrain("chk_neg_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
